// File: rtl/nibble_cla_adder.sv
// Multi-cycle adder: one 4-bit carry-lookahead slice processes one nibble per clock,
// rippling the nibble carry through a register between cycles.
module nibble_cla_adder #(
  parameter int unsigned NIB = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4*NIB-1:0] a,
  input  logic [4*NIB-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [4*NIB-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned W    = 4 * NIB;
  localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            c_q, c_d;
  logic            cout_q, cout_d, ovf_q, ovf_d;

  logic [3:0] nib_a, nib_b, p, g, s;
  logic       c1, c2, c3, c4;

  assign nib_a = a_q[4*idx_q +: 4];
  assign nib_b = b_q[4*idx_q +: 4];
  assign p     = nib_a ^ nib_b;
  assign g     = nib_a & nib_b;

  // Flat lookahead: every carry depends only on p, g and the nibble carry-in.
  assign c1 = g[0] | (p[0] & c_q);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_q);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_q);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & c_q);
  assign s  = p ^ {c3, c2, c1, c_q};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = c_in;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[4*idx_q +: 4] = s;
        c_d   = c4;
        idx_d = idx_q + IdxW'(1);
        if (idx_q == IdxW'(NIB - 1)) begin
          cout_d  = c4;
          ovf_d   = c3 ^ c4;  // carry into the sign bit vs. carry out of it
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);
  assign sum   = sum_q;
  assign c_out = cout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_nibble_cla_adder.sv
// Directed-vector bench for nibble_cla_adder (NIB=4, 16-bit operands).
module tb_nibble_cla_adder;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst, start, c_in;
  logic [W-1:0] a, b;
  logic         busy, done, c_out, ovf;
  logic [W-1:0] sum;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  nibble_cla_adder #(.NIB(NIB)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .c_in (c_in),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .c_out(c_out),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Starts and ends on a negedge; returns in the IDLE cycle after DONE.
  task automatic run_add(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic cv, input logic [W-1:0] es, input logic ec,
                         input logic eo, input bit glitch);
    int cnt;
    start = 1'b1;
    a     = av;
    b     = bv;
    c_in  = cv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a     = 16'hdead;
    b     = 16'hbeef;
    c_in  = 1'b1;
    check({nm, ".busy"}, 32'(busy), 32'd1);
    cnt = 0;
    while (!done && cnt < 20) begin
      if (glitch && cnt == 1) begin
        start = 1'b1;
        a     = 16'hffff;
        b     = 16'hffff;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    start = 1'b0;
    check({nm, ".latency"}, 32'(cnt), 32'(NIB));
    check({nm, ".sum"}, 32'(sum), 32'(es));
    check({nm, ".cout"}, 32'(c_out), 32'(ec));
    check({nm, ".ovf"}, 32'(ovf), 32'(eo));
    check({nm, ".busy_done"}, 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({nm, ".done_pulse"}, 32'(done), 32'd0);
    check({nm, ".hold"}, 32'(sum), 32'(es));
  endtask

  initial begin
    int d0;
    rst   = 1'b1;
    start = 1'b1;
    a     = 16'h1111;
    b     = 16'h1111;
    c_in  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.sum", 32'(sum), 32'd0);
    check("rst.cout", 32'(c_out), 32'd0);
    check("rst.ovf", 32'(ovf), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("idle.busy", 32'(busy), 32'd0);

    run_add("zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    run_add("chain1", 16'hffff, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_add("chain2", 16'hffff, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_add("ovf1", 16'h7fff, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_add("ovf2", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    run_add("mixed", 16'hf0f0, 16'h0f0f, 1'b0, 16'hffff, 1'b0, 1'b0, 1'b0);
    run_add("b2b", 16'h1234, 16'h0ff3, 1'b0, 16'h2227, 1'b0, 1'b0, 1'b0);

    d0 = done_cnt;
    run_add("ignore", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    check("ignore.pulses", 32'(done_cnt - d0), 32'd1);

    // Mid-op reset: leave a non-zero c_out first, then abort in the 2nd RUN cycle.
    run_add("pre", 16'hffff, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    d0    = done_cnt;
    start = 1'b1;
    a     = 16'h1234;
    b     = 16'h1111;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort.partial_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.sum", 32'(sum), 32'd0);
    check("abort.cout", 32'(c_out), 32'd0);
    repeat (8) @(negedge clk);
    check("abort.no_done", 32'(done_cnt - d0), 32'd0);
    check("abort.idle", 32'(busy), 32'd0);
    run_add("post", 16'h0003, 16'h000f, 1'b0, 16'h0012, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
